sdram_port_arbiter: RTL and testbench

SDRAM_PORT_ARBITER -- requirements
Module: sdram_port_arbiter

---
 rtl/rasterizer_pkg.sv | 29 ++
 rtl/arb_pending_fifo.sv | 73 +++++++
 rtl/sdram_port_arbiter.sv | 200 ++++++++++++++++++++
 tb/tb_sdram_port_arbiter.sv | 403 ++++++++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/rasterizer_pkg.sv
// -----------------------------------------------------------------------------
// rasterizer_pkg
// Shared types and constants for the SDRAM port arbiter.
//   arb_state_t : arbiter FSM state (IDLE, BUSY)
//   NUM_REQ     : number of requesters (0 vertex fetch, 1 depth fetch,
//                 2 z-test write)
//   ADDR_W      : SDRAM word-address width
//   DATA_W      : SDRAM data width
//   ID_W        : width of a requester ID
//   rr_next()   : next requester ID in round-robin order (mod NUM_REQ)
// -----------------------------------------------------------------------------
package rasterizer_pkg;

  localparam int NUM_REQ = 3;
  localparam int ADDR_W  = 26;
  localparam int DATA_W  = 32;
  localparam int ID_W    = 2;

  typedef enum logic {
    IDLE = 1'b0,
    BUSY = 1'b1
  } arb_state_t;

  // Successor of a requester ID, wrapping 2 -> 0.
  function automatic logic [ID_W-1:0] rr_next(input logic [ID_W-1:0] id);
    return (id >= 2'd2) ? 2'd0 : id + 2'd1;
  endfunction

endpackage

// File: rtl/arb_pending_fifo.sv
// -----------------------------------------------------------------------------
// arb_pending_fifo
// Queue of requester IDs for reads that SDRAM has accepted but not yet
// returned. Read returns are matched to the head entry, which keeps return
// routing in acceptance order.
//   clk_i, rst_ni : clock, asynchronous active-low reset
//   push_i/id_i   : enqueue id_i (ignored when full unless popping the same cycle)
//   pop_i         : dequeue head (ignored when empty)
//   head_o        : ID at the head of the queue
//   count_o       : number of stored IDs (0..DEPTH)
//   full_o/empty_o: occupancy flags
// -----------------------------------------------------------------------------
module arb_pending_fifo #(
  parameter int DEPTH = 8,
  parameter int WIDTH = 2
) (
  input  logic                     clk_i,
  input  logic                     rst_ni,
  input  logic                     push_i,
  input  logic [WIDTH-1:0]         id_i,
  input  logic                     pop_i,
  output logic [WIDTH-1:0]         head_o,
  output logic [$clog2(DEPTH):0]   count_o,
  output logic                     full_o,
  output logic                     empty_o
);

  localparam int PTR_W = $clog2(DEPTH);
  localparam int CNT_W = PTR_W + 1;

  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d;
  logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d;
  logic [CNT_W-1:0] count_q, count_d;
  logic             push_ok, pop_ok;

  assign full_o  = (count_q == CNT_W'(DEPTH));
  assign empty_o = (count_q == '0);
  assign count_o = count_q;
  assign head_o  = mem_q[rd_ptr_q];

  // A push into a full queue is still safe when the head leaves in the
  // same cycle, so the occupancy stays unchanged.
  assign push_ok = push_i & (~full_o | pop_i);
  assign pop_ok  = pop_i & ~empty_o;

  // DEPTH is a power of two, so pointers wrap by natural overflow.
  always_comb begin
    wr_ptr_d = push_ok ? wr_ptr_q + PTR_W'(1) : wr_ptr_q;
    rd_ptr_d = pop_ok  ? rd_ptr_q + PTR_W'(1) : rd_ptr_q;
    count_d  = count_q + CNT_W'(push_ok) - CNT_W'(pop_ok);
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
    end
  end

  // Storage needs no reset: an entry is only read after it was written.
  always_ff @(posedge clk_i) begin
    if (push_ok) begin
      mem_q[wr_ptr_q] <= id_i;
    end
  end

endmodule

// File: rtl/sdram_port_arbiter.sv
// -----------------------------------------------------------------------------
// sdram_port_arbiter
// Shares one Avalon-MM SDRAM master among three requesters (0 vertex fetch,
// 1 depth fetch, 2 z-test write) with round-robin grants and in-order
// routing of pipelined read returns.
//
// Handshake: a requester presents a command by holding req_read/req_write
// with stable address/data; the command is taken in the cycle its
// req_waitrequest is 0 while the strobe is 1. The same rule applies on the
// master side with m_read/m_write against m_waitrequest. Read data comes
// back later as one-cycle m_readdatavalid pulses, in issue order.
//
// Ports
//   clock, reset          : clock, asynchronous active-low reset
//   req_*                 : per-requester Avalon-MM slave ports
//   req_readdata          : return data, broadcast to all requesters
//   req_readdatavalid     : one-hot strobe naming the owner of req_readdata
//   m_*                   : Avalon-MM master toward SDRAM
//   busy                  : command in flight or reads outstanding
//   pending_count         : reads accepted by SDRAM but not yet returned
//   protocol_error        : sticky; read+write together, or orphan return
//   dbg_state             : current FSM state
// -----------------------------------------------------------------------------
module sdram_port_arbiter
  import rasterizer_pkg::*;
#(
  parameter int MAX_PENDING = 8
) (
  input  logic                             clock,
  input  logic                             reset,
  input  logic [NUM_REQ-1:0][ADDR_W-1:0]   req_address,
  input  logic [NUM_REQ-1:0]               req_read,
  input  logic [NUM_REQ-1:0]               req_write,
  input  logic [NUM_REQ-1:0][3:0]          req_byteenable,
  input  logic [NUM_REQ-1:0][DATA_W-1:0]   req_writedata,
  output logic [NUM_REQ-1:0]               req_waitrequest,
  output logic [DATA_W-1:0]                req_readdata,
  output logic [NUM_REQ-1:0]               req_readdatavalid,
  output logic [ADDR_W-1:0]                m_address,
  output logic                             m_read,
  output logic                             m_write,
  output logic [3:0]                       m_byteenable,
  output logic [DATA_W-1:0]                m_writedata,
  input  logic [DATA_W-1:0]                m_readdata,
  input  logic                             m_readdatavalid,
  input  logic                             m_waitrequest,
  output logic                             busy,
  output logic [4:0]                       pending_count,
  output logic                             protocol_error,
  output arb_state_t                       dbg_state
);

  localparam int CNT_W = $clog2(MAX_PENDING) + 1;

  arb_state_t        state_q;
  logic [ID_W-1:0]   grant_q;
  logic [ID_W-1:0]   last_grant_q;
  logic              protocol_error_q, protocol_error_d;

  logic [NUM_REQ-1:0] eligible;
  logic               any_eligible;
  logic [ID_W-1:0]    cand1, cand2, cand3, pick;
  logic               in_busy;
  logic               gnt_read, gnt_write;
  logic               push, pop;

  logic [ID_W-1:0]    fifo_head;
  logic [CNT_W-1:0]   fifo_count;
  logic               fifo_full, fifo_empty;

  // ---------------------------------------------------------------------------
  // Pending read-ID queue
  // ---------------------------------------------------------------------------
  arb_pending_fifo #(
    .DEPTH (MAX_PENDING),
    .WIDTH (ID_W)
  ) u_pending (
    .clk_i   (clock),
    .rst_ni  (reset),
    .push_i  (push),
    .id_i    (grant_q),
    .pop_i   (pop),
    .head_o  (fifo_head),
    .count_o (fifo_count),
    .full_o  (fifo_full),
    .empty_o (fifo_empty)
  );

  // ---------------------------------------------------------------------------
  // Grant selection
  // ---------------------------------------------------------------------------
  // Writes never occupy a queue slot, so a full queue only holds off reads.
  assign eligible     = req_write | (req_read & {NUM_REQ{~fifo_full}});
  assign any_eligible = |eligible;

  // Search order starts just after the last accepted requester; the third
  // candidate is last_grant itself.
  always_comb begin
    cand1 = rr_next(last_grant_q);
    cand2 = rr_next(cand1);
    cand3 = rr_next(cand2);
    pick  = cand3;
    if (eligible[cand1]) begin
      pick = cand1;
    end else if (eligible[cand2]) begin
      pick = cand2;
    end
  end

  // ---------------------------------------------------------------------------
  // Master command path: mirrors the granted requester while BUSY
  // ---------------------------------------------------------------------------
  assign in_busy   = (state_q == BUSY);
  assign gnt_read  = req_read[grant_q];
  assign gnt_write = req_write[grant_q];

  // A requester strobing both read and write is treated as a write.
  assign m_write      = in_busy & gnt_write;
  assign m_read       = in_busy & gnt_read & ~gnt_write;
  assign m_address    = req_address[grant_q];
  assign m_byteenable = req_byteenable[grant_q];
  assign m_writedata  = req_writedata[grant_q];

  always_comb begin
    req_waitrequest = '1;
    if (in_busy) begin
      req_waitrequest[grant_q] = m_waitrequest;
    end
  end

  // m_read already implies BUSY; accepted when SDRAM does not stall.
  assign push = m_read & ~m_waitrequest;

  // ---------------------------------------------------------------------------
  // Read return path
  // ---------------------------------------------------------------------------
  assign pop          = m_readdatavalid & ~fifo_empty;
  assign req_readdata = m_readdata;

  always_comb begin
    req_readdatavalid = '0;
    if (pop) begin
      req_readdatavalid[fifo_head] = 1'b1;
    end
  end

  // ---------------------------------------------------------------------------
  // FSM
  // ---------------------------------------------------------------------------
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      state_q      <= IDLE;
      grant_q      <= 2'd0;
      last_grant_q <= 2'd2;
    end else begin
      case (state_q)
        IDLE: begin
          if (any_eligible) begin
            grant_q <= pick;
            state_q <= BUSY;
          end
        end
        BUSY: begin
          if (!(gnt_read || gnt_write)) begin
            // Requester withdrew: release without crediting its turn.
            state_q <= IDLE;
          end else if (!m_waitrequest) begin
            last_grant_q <= grant_q;
            state_q      <= IDLE;
          end
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  // ---------------------------------------------------------------------------
  // Sticky protocol error
  // ---------------------------------------------------------------------------
  assign protocol_error_d = protocol_error_q
                          | (in_busy & gnt_read & gnt_write)
                          | (m_readdatavalid & fifo_empty);

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      protocol_error_q <= 1'b0;
    end else begin
      protocol_error_q <= protocol_error_d;
    end
  end

  // ---------------------------------------------------------------------------
  // Status
  // ---------------------------------------------------------------------------
  assign protocol_error = protocol_error_q;
  assign pending_count  = 5'(fifo_count);
  assign busy           = in_busy | ~fifo_empty;
  assign dbg_state      = state_q;

endmodule

// File: tb/tb_sdram_port_arbiter.sv
// -----------------------------------------------------------------------------
// tb_sdram_port_arbiter
// Directed scenarios for the SDRAM port arbiter. Each cycle: inputs are
// driven 1 time unit after the rising edge, outputs sampled 2 units later.
// Cycle 0 of a scenario is the first cycle its requests are visible.
// -----------------------------------------------------------------------------
module tb_sdram_port_arbiter;
  import rasterizer_pkg::*;

  logic                clock = 1'b0;
  logic                reset;
  logic [2:0][25:0]    req_address;
  logic [2:0]          req_read;
  logic [2:0]          req_write;
  logic [2:0][3:0]     req_byteenable;
  logic [2:0][31:0]    req_writedata;
  logic [2:0]          req_waitrequest;
  logic [31:0]         req_readdata;
  logic [2:0]          req_readdatavalid;
  logic [25:0]         m_address;
  logic                m_read;
  logic                m_write;
  logic [3:0]          m_byteenable;
  logic [31:0]         m_writedata;
  logic [31:0]         m_readdata;
  logic                m_readdatavalid;
  logic                m_waitrequest;
  logic                busy;
  logic [4:0]          pending_count;
  logic                protocol_error;
  arb_state_t          dbg_state;

  int n_checks = 0;
  int n_fail   = 0;

  sdram_port_arbiter #(.MAX_PENDING(8)) dut (
    .clock             (clock),
    .reset             (reset),
    .req_address       (req_address),
    .req_read          (req_read),
    .req_write         (req_write),
    .req_byteenable    (req_byteenable),
    .req_writedata     (req_writedata),
    .req_waitrequest   (req_waitrequest),
    .req_readdata      (req_readdata),
    .req_readdatavalid (req_readdatavalid),
    .m_address         (m_address),
    .m_read            (m_read),
    .m_write           (m_write),
    .m_byteenable      (m_byteenable),
    .m_writedata       (m_writedata),
    .m_readdata        (m_readdata),
    .m_readdatavalid   (m_readdatavalid),
    .m_waitrequest     (m_waitrequest),
    .busy              (busy),
    .pending_count     (pending_count),
    .protocol_error    (protocol_error),
    .dbg_state         (dbg_state)
  );

  // ---------------------------------------------------------------------------
  // Clock / reset / drivers
  // ---------------------------------------------------------------------------
  always #5 clock = ~clock;

  task automatic step();
    @(posedge clock);
    #1;
  endtask

  task automatic settle();
    #2;
  endtask

  task automatic idle_inputs();
    req_address     = '0;
    req_read        = '0;
    req_write       = '0;
    req_byteenable  = '0;
    req_writedata   = '0;
    m_readdata      = '0;
    m_readdatavalid = 1'b0;
    m_waitrequest   = 1'b0;
  endtask

  task automatic apply_reset();
    idle_inputs();
    reset = 1'b0;
    repeat (2) step();
    reset = 1'b1;
  endtask

  // ---------------------------------------------------------------------------
  // Reset values, with requests and a stray return present during reset
  // ---------------------------------------------------------------------------
  task automatic test_reset();
    idle_inputs();
    reset = 1'b1;
    step();
    req_read        = 3'b111;
    req_write       = 3'b100;
    m_readdatavalid = 1'b1;
    reset           = 1'b0;
    #1;
    n_checks++; if (req_waitrequest !== 3'b111) begin n_fail++; $display("FAIL reset waitrequest: got %b expected 111", req_waitrequest); end
    n_checks++; if (m_read !== 1'b0) begin n_fail++; $display("FAIL reset m_read: got %b expected 0", m_read); end
    n_checks++; if (m_write !== 1'b0) begin n_fail++; $display("FAIL reset m_write: got %b expected 0", m_write); end
    n_checks++; if (req_readdatavalid !== 3'b000) begin n_fail++; $display("FAIL reset readdatavalid: got %b expected 000", req_readdatavalid); end
    n_checks++; if (busy !== 1'b0) begin n_fail++; $display("FAIL reset busy: got %b expected 0", busy); end
    n_checks++; if (pending_count !== 5'd0) begin n_fail++; $display("FAIL reset pending_count: got %0d expected 0", pending_count); end
    repeat (2) step();
    settle();
    n_checks++; if (protocol_error !== 1'b0) begin n_fail++; $display("FAIL reset protocol_error: got %b expected 0", protocol_error); end
    n_checks++; if (dbg_state !== IDLE) begin n_fail++; $display("FAIL reset state: got %0d expected IDLE", dbg_state); end
    n_checks++; if (m_write !== 1'b0) begin n_fail++; $display("FAIL reset held m_write: got %b expected 0", m_write); end
    idle_inputs();
    reset = 1'b1;
  endtask

  // ---------------------------------------------------------------------------
  // Three simultaneous reads, SDRAM latency 3, no stalls
  // ---------------------------------------------------------------------------
  task automatic test_rr_reads();
    logic [2:0]  hold;
    logic        ret_v [16];
    logic [31:0] ret_d [16];
    logic [25:0] addr  [3];
    logic        exp_rd;
    logic [2:0]  exp_rdv;
    int          who;
    addr[0] = 26'h0000011;
    addr[1] = 26'h0000222;
    addr[2] = 26'h0003333;
    for (int i = 0; i < 16; i++) begin
      ret_v[i] = 1'b0;
      ret_d[i] = '0;
    end
    apply_reset();
    for (int i = 0; i < 3; i++) req_address[i] = addr[i];
    hold = 3'b111;
    for (int cyc = 0; cyc < 10; cyc++) begin
      step();
      req_read        = hold;
      m_waitrequest   = 1'b0;
      m_readdatavalid = ret_v[cyc];
      m_readdata      = ret_d[cyc];
      settle();
      exp_rd = (cyc == 1 || cyc == 3 || cyc == 5);
      who    = (cyc - 1) / 2;
      n_checks++; if (m_read !== exp_rd) begin n_fail++; $display("FAIL rr m_read cyc%0d: got %b expected %b", cyc, m_read, exp_rd); end
      if (exp_rd) begin
        n_checks++; if (m_address !== addr[who]) begin n_fail++; $display("FAIL rr m_address cyc%0d: got %h expected %h", cyc, m_address, addr[who]); end
        n_checks++; if (req_waitrequest !== ~(3'b001 << who)) begin n_fail++; $display("FAIL rr waitrequest cyc%0d: got %b", cyc, req_waitrequest); end
      end else begin
        n_checks++; if (req_waitrequest !== 3'b111) begin n_fail++; $display("FAIL rr waitrequest idle cyc%0d: got %b expected 111", cyc, req_waitrequest); end
      end
      exp_rdv = (cyc == 4) ? 3'b001 : (cyc == 6) ? 3'b010 : (cyc == 8) ? 3'b100 : 3'b000;
      n_checks++; if (req_readdatavalid !== exp_rdv) begin n_fail++; $display("FAIL rr readdatavalid cyc%0d: got %b expected %b", cyc, req_readdatavalid, exp_rdv); end
      if (exp_rdv != 3'b000) begin
        who = (cyc - 4) / 2;
        n_checks++; if (req_readdata !== (32'hD00D0000 | 32'(addr[who]))) begin n_fail++; $display("FAIL rr readdata cyc%0d: got %h", cyc, req_readdata); end
      end
      if (cyc == 2) begin
        n_checks++; if (pending_count !== 5'd1) begin n_fail++; $display("FAIL rr pending cyc2: got %0d expected 1", pending_count); end
      end
      if (cyc == 9) begin
        n_checks++; if (busy !== 1'b0) begin n_fail++; $display("FAIL rr busy end: got %b expected 0", busy); end
      end
      for (int i = 0; i < 3; i++) if (hold[i] && !req_waitrequest[i]) hold[i] = 1'b0;
      // SDRAM model: data tagged with the read address, three cycles later.
      if (m_read && !m_waitrequest && cyc + 3 < 16) begin
        ret_v[cyc+3] = 1'b1;
        ret_d[cyc+3] = 32'hD00D0000 | 32'(m_address);
      end
    end
    idle_inputs();
  endtask

  // ---------------------------------------------------------------------------
  // Write from requester 2 stalled by SDRAM for four cycles
  // ---------------------------------------------------------------------------
  task automatic test_write_stall();
    logic wr_hold;
    logic exp_wr;
    apply_reset();
    wr_hold = 1'b1;
    for (int cyc = 0; cyc < 8; cyc++) begin
      step();
      req_write[2]      = wr_hold;
      req_address[2]    = 26'h0100000;
      req_writedata[2]  = 32'h00AABBCC;
      req_byteenable[2] = 4'hF;
      m_waitrequest     = (cyc >= 1 && cyc <= 4);
      settle();
      exp_wr = (cyc >= 1 && cyc <= 5);
      n_checks++; if (m_write !== exp_wr) begin n_fail++; $display("FAIL wr m_write cyc%0d: got %b expected %b", cyc, m_write, exp_wr); end
      n_checks++; if (m_read !== 1'b0) begin n_fail++; $display("FAIL wr m_read cyc%0d: got %b expected 0", cyc, m_read); end
      if (exp_wr) begin
        n_checks++; if (m_address !== 26'h0100000) begin n_fail++; $display("FAIL wr m_address cyc%0d: got %h expected 0100000", cyc, m_address); end
        n_checks++; if (m_writedata !== 32'h00AABBCC) begin n_fail++; $display("FAIL wr m_writedata cyc%0d: got %h expected 00aabbcc", cyc, m_writedata); end
        n_checks++; if (m_byteenable !== 4'hF) begin n_fail++; $display("FAIL wr m_byteenable cyc%0d: got %h expected f", cyc, m_byteenable); end
      end
      n_checks++; if (req_waitrequest !== ((cyc == 5) ? 3'b011 : 3'b111)) begin n_fail++; $display("FAIL wr waitrequest cyc%0d: got %b", cyc, req_waitrequest); end
      n_checks++; if (pending_count !== 5'd0) begin n_fail++; $display("FAIL wr pending cyc%0d: got %0d expected 0", cyc, pending_count); end
      if (req_write[2] && !req_waitrequest[2]) wr_hold = 1'b0;
    end
    idle_inputs();
  endtask

  // ---------------------------------------------------------------------------
  // Requester 0 keeps reading, SDRAM never returns: queue fills at 8,
  // further reads stall, a write from requester 2 still gets through
  // ---------------------------------------------------------------------------
  task automatic test_full();
    int accepted;
    apply_reset();
    accepted = 0;
    req_address[0] = 26'h0000400;
    for (int cyc = 0; cyc < 20; cyc++) begin
      step();
      req_read[0]   = 1'b1;
      m_waitrequest = 1'b0;
      settle();
      if (m_read && !req_waitrequest[0]) accepted++;
      if (cyc >= 16) begin
        n_checks++; if (m_read !== 1'b0) begin n_fail++; $display("FAIL full m_read cyc%0d: got %b expected 0", cyc, m_read); end
        n_checks++; if (req_waitrequest[0] !== 1'b1) begin n_fail++; $display("FAIL full waitrequest0 cyc%0d: got %b expected 1", cyc, req_waitrequest[0]); end
        n_checks++; if (pending_count !== 5'd8) begin n_fail++; $display("FAIL full pending cyc%0d: got %0d expected 8", cyc, pending_count); end
      end
    end
    n_checks++; if (accepted !== 8) begin n_fail++; $display("FAIL full accepted: got %0d expected 8", accepted); end
    // cycle 20: write request appears
    step();
    req_write[2]   = 1'b1;
    req_address[2] = 26'h0000777;
    settle();
    n_checks++; if (m_write !== 1'b0) begin n_fail++; $display("FAIL full write early: got %b expected 0", m_write); end
    // cycle 21: write issued
    step();
    settle();
    n_checks++; if (dbg_state !== BUSY) begin n_fail++; $display("FAIL full write state: got %0d expected BUSY", dbg_state); end
    n_checks++; if (m_write !== 1'b1) begin n_fail++; $display("FAIL full write m_write: got %b expected 1", m_write); end
    n_checks++; if (m_address !== 26'h0000777) begin n_fail++; $display("FAIL full write m_address: got %h expected 0000777", m_address); end
    n_checks++; if (req_waitrequest !== 3'b011) begin n_fail++; $display("FAIL full write waitrequest: got %b expected 011", req_waitrequest); end
    // cycle 22: write done, read still blocked
    step();
    req_write[2] = 1'b0;
    settle();
    n_checks++; if (m_read !== 1'b0) begin n_fail++; $display("FAIL full after write m_read: got %b expected 0", m_read); end
    n_checks++; if (pending_count !== 5'd8) begin n_fail++; $display("FAIL full after write pending: got %0d expected 8", pending_count); end
    n_checks++; if (busy !== 1'b1) begin n_fail++; $display("FAIL full busy: got %b expected 1", busy); end
    idle_inputs();
  endtask

  // ---------------------------------------------------------------------------
  // 20 reads from all three requesters: fill to 8, then returns every other
  // cycle so each accept coincides with a pop; order and wrap are checked
  // ---------------------------------------------------------------------------
  task automatic test_back_to_back();
    int         rem [3];
    int         ret_k;
    int         accepted;
    logic [2:0] exp_rdv;
    apply_reset();
    rem[0] = 7;
    rem[1] = 7;
    rem[2] = 6;
    ret_k    = 0;
    accepted = 0;
    for (int i = 0; i < 3; i++) req_address[i] = 26'h0001000 + 26'(i);
    for (int cyc = 0; cyc < 61; cyc++) begin
      step();
      for (int i = 0; i < 3; i++) req_read[i] = (rem[i] > 0);
      m_waitrequest   = 1'b0;
      m_readdatavalid = (cyc >= 18 && cyc <= 56 && (cyc % 2) == 0);
      m_readdata      = 32'hC0DE0000 + 32'(ret_k);
      settle();
      if (m_readdatavalid) begin
        exp_rdv = 3'b001 << (ret_k % 3);
        n_checks++; if (req_readdatavalid !== exp_rdv) begin n_fail++; $display("FAIL b2b strobe k%0d: got %b expected %b", ret_k, req_readdatavalid, exp_rdv); end
        n_checks++; if (req_readdata !== 32'hC0DE0000 + 32'(ret_k)) begin n_fail++; $display("FAIL b2b readdata k%0d: got %h", ret_k, req_readdata); end
        ret_k++;
      end else begin
        n_checks++; if (req_readdatavalid !== 3'b000) begin n_fail++; $display("FAIL b2b stray strobe cyc%0d: got %b expected 000", cyc, req_readdatavalid); end
      end
      if (cyc == 17) begin
        n_checks++; if (pending_count !== 5'd8) begin n_fail++; $display("FAIL b2b fill pending: got %0d expected 8", pending_count); end
      end
      if (cyc >= 21 && cyc <= 43 && (cyc % 2) == 1) begin
        n_checks++; if (pending_count !== 5'd7) begin n_fail++; $display("FAIL b2b steady pending cyc%0d: got %0d expected 7", cyc, pending_count); end
      end
      if (cyc == 60) begin
        n_checks++; if (pending_count !== 5'd0) begin n_fail++; $display("FAIL b2b drain pending: got %0d expected 0", pending_count); end
        n_checks++; if (busy !== 1'b0) begin n_fail++; $display("FAIL b2b drain busy: got %b expected 0", busy); end
      end
      for (int i = 0; i < 3; i++) begin
        if (req_read[i] && !req_waitrequest[i]) begin
          rem[i]--;
          accepted++;
        end
      end
    end
    n_checks++; if (accepted !== 20) begin n_fail++; $display("FAIL b2b accepted: got %0d expected 20", accepted); end
    n_checks++; if (ret_k !== 20) begin n_fail++; $display("FAIL b2b returns: got %0d expected 20", ret_k); end
    idle_inputs();
  endtask

  // ---------------------------------------------------------------------------
  // Orphan return, read+write conflict, reset with reads outstanding
  // ---------------------------------------------------------------------------
  task automatic test_errors_and_reset();
    logic [2:0] hold;
    apply_reset();
    step();
    m_readdatavalid = 1'b1;
    m_readdata      = 32'hDEAD0001;
    settle();
    n_checks++; if (req_readdatavalid !== 3'b000) begin n_fail++; $display("FAIL orphan strobe: got %b expected 000", req_readdatavalid); end
    n_checks++; if (protocol_error !== 1'b0) begin n_fail++; $display("FAIL orphan error early: got %b expected 0", protocol_error); end
    step();
    m_readdatavalid = 1'b0;
    settle();
    n_checks++; if (protocol_error !== 1'b1) begin n_fail++; $display("FAIL orphan error: got %b expected 1", protocol_error); end
    repeat (3) step();
    settle();
    n_checks++; if (protocol_error !== 1'b1) begin n_fail++; $display("FAIL orphan error sticky: got %b expected 1", protocol_error); end

    // read and write together from requester 1
    apply_reset();
    #1;
    n_checks++; if (protocol_error !== 1'b0) begin n_fail++; $display("FAIL conflict error cleared: got %b expected 0", protocol_error); end
    step();
    req_read[1]    = 1'b1;
    req_write[1]   = 1'b1;
    req_address[1] = 26'h0000055;
    settle();
    step();
    settle();
    n_checks++; if (m_write !== 1'b1) begin n_fail++; $display("FAIL conflict m_write: got %b expected 1", m_write); end
    n_checks++; if (m_read !== 1'b0) begin n_fail++; $display("FAIL conflict m_read: got %b expected 0", m_read); end
    n_checks++; if (req_waitrequest !== 3'b101) begin n_fail++; $display("FAIL conflict waitrequest: got %b expected 101", req_waitrequest); end
    step();
    req_read[1]  = 1'b0;
    req_write[1] = 1'b0;
    settle();
    n_checks++; if (protocol_error !== 1'b1) begin n_fail++; $display("FAIL conflict error: got %b expected 1", protocol_error); end
    n_checks++; if (pending_count !== 5'd0) begin n_fail++; $display("FAIL conflict pending: got %0d expected 0", pending_count); end

    // three reads outstanding, then reset during a fourth command
    apply_reset();
    hold = 3'b111;
    for (int cyc = 0; cyc < 6; cyc++) begin
      step();
      req_read = hold;
      settle();
      for (int i = 0; i < 3; i++) if (hold[i] && !req_waitrequest[i]) hold[i] = 1'b0;
    end
    step();
    req_read = 3'b001;
    settle();
    n_checks++; if (pending_count !== 5'd3) begin n_fail++; $display("FAIL rst pending before: got %0d expected 3", pending_count); end
    step();
    settle();
    n_checks++; if (m_read !== 1'b1) begin n_fail++; $display("FAIL rst in-flight m_read: got %b expected 1", m_read); end
    reset = 1'b0;
    #1;
    n_checks++; if (pending_count !== 5'd0) begin n_fail++; $display("FAIL rst pending: got %0d expected 0", pending_count); end
    n_checks++; if (busy !== 1'b0) begin n_fail++; $display("FAIL rst busy: got %b expected 0", busy); end
    n_checks++; if (m_read !== 1'b0) begin n_fail++; $display("FAIL rst m_read: got %b expected 0", m_read); end
    n_checks++; if (req_waitrequest !== 3'b111) begin n_fail++; $display("FAIL rst waitrequest: got %b expected 111", req_waitrequest); end
    n_checks++; if (protocol_error !== 1'b0) begin n_fail++; $display("FAIL rst error: got %b expected 0", protocol_error); end
    idle_inputs();
    repeat (2) step();
    reset = 1'b1;
    // late return for a discarded read
    step();
    m_readdatavalid = 1'b1;
    settle();
    n_checks++; if (req_readdatavalid !== 3'b000) begin n_fail++; $display("FAIL late return strobe: got %b expected 000", req_readdatavalid); end
    step();
    m_readdatavalid = 1'b0;
    settle();
    n_checks++; if (protocol_error !== 1'b1) begin n_fail++; $display("FAIL late return error: got %b expected 1", protocol_error); end
    idle_inputs();
  endtask

  // ---------------------------------------------------------------------------
  // Sequence and report
  // ---------------------------------------------------------------------------
  initial begin
    idle_inputs();
    reset = 1'b1;
    test_reset();
    test_rr_reads();
    test_write_stall();
    test_full();
    test_back_to_back();
    test_errors_and_reset();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
